de_issue_queue: RTL and testbench
=================================

Name: de_issue_queue

Overview:
Decoupling instruction queue between fetch and decode for the dual-pipe (alpha/beta) core. Accepts up to two fetched instructions per cycle and presents up to two per cycle to the alpha/beta decoders. Pairing rules come from a light predecode: RAW, single memory port, branch/delay-slot pairing and privileged-alone. Generalises the single-slot decode front end to parametrised depth with buffering and dual issue.

Parameters:
DEPTH, 8, queue entries; power of two, >= 4
PC_W, 32, width of stored PC per entry

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous queue clear (exception/branch redirect)
in_valid  in  2  per-slot fetch valid; bit1 set only if bit0 set
in_inst  in  64  slot0 = [31:0], slot1 = [63:32]
in_pc  in  2*PC_W  slot0 low, slot1 high
in_ready  out  1  queue has >= 2 free entries
issue_ready  in  1  decode stage accepts this cycle
alpha_valid  out  1  head entry issued in alpha slot
alpha_inst  out  32  head instruction
alpha_pc  out  PC_W  head PC
beta_valid  out  1  second entry issued in beta slot
beta_inst  out  32  second instruction
beta_pc  out  PC_W  second PC
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: DEPTH x {inst, pc} registers; rd_ptr and wr_ptr wrap modulo DEPTH; count is registered.
- Reset: pointers = 0, count = 0. All outputs read 0 and valids read 0. in_ready = 1.
- Push: when in_ready && in_valid[0], write slot0 at wr_ptr and slot1 (if valid) at wr_ptr+1. wr_ptr advances by popcount(in_valid). Pushes while !in_ready are dropped; fetch must hold.
- in_ready = (DEPTH - count) >= 2. It uses the registered count, so a same-cycle pop does not matter.
- Outputs are combinational from head entries; zero-latency issue after a write is registered (entry visible the cycle after push).
- alpha_valid = count >= 1, except a branch/jump at head with count == 1: alpha holds for its delay slot.
- beta_valid = count >= 2 && alpha_valid && pair_ok.
- pair_ok is false if any of:
  - alpha or beta is priv (opcode 010000, or SPECIAL funct 001100/001101);
  - beta is branch/jump (opcode 000001/00001x/0001xx, or SPECIAL funct 00100x);
  - alpha and beta are both memory ops (opcode 10xxxx);
  - alpha dest != 0 and alpha dest equals beta rs or rt.
- alpha dest rules: rd for SPECIAL; rt for opcode 001xxx/100xxx and MFC0; 31 for JAL and BxxZAL; else none.
- Exception: a branch in alpha with its delay slot in beta is always paired, unless the delay slot is priv or has a RAW on $31/rd. In that case the branch issues alone.
- Pop: when issue_ready, rd_ptr and count advance by alpha_valid + beta_valid. When issue_ready = 0, outputs hold stable.
- Simultaneous push and pop: count_next = count + pushed - popped.
- flush has priority over push and pop: next cycle count = 0 and rd_ptr = wr_ptr. Same-cycle inputs are ignored.
- Reset mid-operation: immediate return to reset state; queued entries are discarded.

Optional Feature:
DE_DUAL_ISSUE_EN.
- Defined: dual issue as above.
- Undefined: beta_valid is tied to 0 and pop is at most 1 per cycle. The branch hold-for-delay-slot rule is removed; branches issue alone. in_ready is unchanged.

Decomposition:
- Package de_pkg: opcode/funct localparams (SPECIAL, REGIMM, COP0, J/JAL, SYSCALL/BREAK functs) and a predecode struct typedef {is_branch, is_link, is_mem, is_priv, dest, dest_en, rs, rt}.
- One sub-module de_predecode: combinational, instruction -> predecode struct, instantiated for alpha and beta heads.

Test Plan:
- Reset: assert rst_n=0 mid-push -> count=0, alpha_valid=0, beta_valid=0, in_ready=1 immediately.
- RAW split: push 0x00221821 (ADDU $3,$1,$2) and 0x00612021 (ADDU $4,$3,$1), issue_ready=1 -> cycle1 alpha only; cycle2 alpha=0x00612021.
- Independent pair and memory conflict:
  - push 0x00221821 + 0x24050001 -> both issue same cycle, count 2->0;
  - push 0x8C060000 (LW) + 0xAC060004 (SW) -> LW alone.
- Branch delay slot: push 0x10000004 (BEQ) alone -> alpha_valid=0; next push 0x24050001 -> both issue paired.
- Priv alone: push 0x0000000C (SYSCALL) + 0x42000018 (ERET) -> each issues alone in consecutive cycles.
- Full/wrap/flush:
  - DEPTH=8 with issue_ready=0: fill to count=8, in_ready=0 at count>=7, extra pushes dropped;
  - release over 4 cycles: pointers wrap, order preserved;
  - flush with simultaneous push -> count=0 next cycle.

Source files
------------

// File: rtl/de_pkg.sv
// Shared decode-front-end definitions: opcode/funct encodings and the
// predecode record that drives the alpha/beta pairing decision.
package de_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_COP0    = 6'b010000;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic       is_branch;
    logic       is_link;
    logic       is_mem;
    logic       is_priv;
    logic [4:0] dest;
    logic       dest_en;
    logic [4:0] rs;
    logic [4:0] rt;
  } pdec_t;

  // Younger instruction reads a register the older one writes ($0 never counts).
  function automatic logic raw_hazard(input pdec_t a, input pdec_t b);
    return a.dest_en && (a.dest != 5'd0) && ((a.dest == b.rs) || (a.dest == b.rt));
  endfunction

endpackage

// File: rtl/de_predecode.sv
// Light combinational predecode of one queued instruction into the fields
// needed for issue pairing.
module de_predecode
  import de_pkg::*;
(
  input  logic [31:0] inst,
  output pdec_t       pd
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       special;
  logic       link_regimm;

  assign op          = inst[31:26];
  assign fn          = inst[5:0];
  assign special     = (op == OP_SPECIAL);
  // BLTZAL/BGEZAL family: REGIMM with rt = 1000x
  assign link_regimm = (op == OP_REGIMM) && (inst[20:17] == 4'b1000);

  always_comb begin
    pd           = '0;
    pd.rs        = inst[25:21];
    pd.rt        = inst[20:16];
    pd.is_branch = (op == OP_REGIMM) || (op == OP_J) || (op == OP_JAL) ||
                   (op[5:2] == 4'b0001) ||
                   (special && ((fn == FN_JR) || (fn == FN_JALR)));
    pd.is_priv   = (op == OP_COP0) || (special && ((fn == FN_SYSCALL) || (fn == FN_BREAK)));
    pd.is_mem    = (op[5:4] == 2'b10);
    pd.is_link   = (op == OP_JAL) || link_regimm || (special && (fn == FN_JALR));
    if (special) begin
      pd.dest    = inst[15:11];
      pd.dest_en = 1'b1;
    end else if ((op[5:3] == 3'b001) || (op[5:3] == 3'b100) ||
                 ((op == OP_COP0) && (inst[25:21] == 5'b00000))) begin
      pd.dest    = inst[20:16];
      pd.dest_en = 1'b1;
    end else if ((op == OP_JAL) || link_regimm) begin
      pd.dest    = REG_RA;
      pd.dest_en = 1'b1;
    end
  end

endmodule

// File: rtl/de_issue_queue.sv
// Fetch/decode decoupling queue presenting up to two instructions per cycle
// to the alpha/beta decoders. Dual issue is enabled by `define DE_DUAL_ISSUE_EN.
module de_issue_queue
  import de_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [63:0]              in_inst,
  input  logic [2*PC_W-1:0]        in_pc,
  output logic                     in_ready,
  input  logic                     issue_ready,
  output logic                     alpha_valid,
  output logic [31:0]              alpha_inst,
  output logic [PC_W-1:0]          alpha_pc,
  output logic                     beta_valid,
  output logic [31:0]              beta_inst,
  output logic [PC_W-1:0]          beta_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;
  localparam int NUM_LANES = 2;

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic [CW-1:0] count_q, push_n, pop_n;

  logic [NUM_LANES-1:0][31:0]     head_inst;
  logic [NUM_LANES-1:0][PC_W-1:0] head_pc;
  pdec_t [NUM_LANES-1:0]          head_pd;

  logic occ1, occ2, do_push, push_two;
  logic unused_pd;

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [PW-1:0] idx;
      assign idx          = rd_ptr + PW'(l);
      assign head_inst[l] = inst_mem[idx];
      assign head_pc[l]   = pc_mem[idx];
      de_predecode u_pd (.inst(head_inst[l]), .pd(head_pd[l]));
    end
  endgenerate

  // Not every predecode field feeds the issue decision in every build.
  assign unused_pd = ^head_pd;

  assign occ1     = (count_q != '0);
  assign occ2     = (count_q >= CW'(2));
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign do_push  = in_ready && in_valid[0];
  assign push_two = do_push && in_valid[1];
  assign wr_ptr1  = wr_ptr + PW'(1);

`ifdef DE_DUAL_ISSUE_EN
  logic raw, pair_ok;
  assign raw = raw_hazard(head_pd[0], head_pd[1]);

  // A branch always travels with its delay slot unless that slot is
  // privileged or consumes the branch's link register.
  always_comb begin
    pair_ok = 1'b0;
    if (head_pd[0].is_branch)
      pair_ok = !head_pd[1].is_priv && !raw;
    else
      pair_ok = !(head_pd[0].is_priv || head_pd[1].is_priv) &&
                !head_pd[1].is_branch &&
                !(head_pd[0].is_mem && head_pd[1].is_mem) &&
                !raw;
  end

  assign alpha_valid = occ1 && !(head_pd[0].is_branch && (count_q == CW'(1)));
  assign beta_valid  = occ2 && alpha_valid && pair_ok;
`else
  assign alpha_valid = occ1;
  assign beta_valid  = 1'b0;
`endif

  assign alpha_inst = occ1 ? head_inst[0] : '0;
  assign alpha_pc   = occ1 ? head_pc[0]   : '0;
  assign beta_inst  = occ2 ? head_inst[1] : '0;
  assign beta_pc    = occ2 ? head_pc[1]   : '0;
  assign count      = count_q;

  assign push_n = CW'(do_push) + CW'(push_two);
  assign pop_n  = issue_ready ? (CW'(alpha_valid) + CW'(beta_valid)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + push_n[PW-1:0];
      rd_ptr  <= rd_ptr + pop_n[PW-1:0];
      count_q <= count_q + push_n - pop_n;
    end
  end

  // Payload storage needs no reset: occupancy gates everything visible.
  always_ff @(posedge clk) begin
    if (!flush && do_push) begin
      inst_mem[wr_ptr] <= in_inst[31:0];
      pc_mem[wr_ptr]   <= in_pc[PC_W-1:0];
      if (push_two) begin
        inst_mem[wr_ptr1] <= in_inst[63:32];
        pc_mem[wr_ptr1]   <= in_pc[2*PC_W-1:PC_W];
      end
    end
  end

endmodule

// File: tb/tb_de_issue_queue.sv
// Directed bench for de_issue_queue; expectations adapt to DE_DUAL_ISSUE_EN.
module tb_de_issue_queue;

`ifdef DE_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk, rst_n, flush;
  logic [1:0]  in_valid;
  logic [63:0] in_inst;
  logic [63:0] in_pc;
  logic        in_ready, issue_ready;
  logic        alpha_valid, beta_valid;
  logic [31:0] alpha_inst, beta_inst, alpha_pc, beta_pc;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  de_issue_queue #(.DEPTH(8), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .issue_ready(issue_ready),
    .alpha_valid(alpha_valid), .alpha_inst(alpha_inst), .alpha_pc(alpha_pc),
    .beta_valid(beta_valid), .beta_inst(beta_inst), .beta_pc(beta_pc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0);
    in_valid = v;
    in_inst  = {i1, i0};
    in_pc    = {p0 + 32'd4, p0};
  endtask

  task automatic idle();
    in_valid = 2'b00;
    in_inst  = '0;
    in_pc    = '0;
  endtask

  function automatic logic [31:0] addiu(input int k);
    return 32'h2400_0000 | (32'(k) << 16) | 32'(k);
  endfunction

  function automatic logic [31:0] pcof(input int k);
    return 32'h1000 + 32'(4 * k);
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_alpha_v", alpha_valid, 0);
    chk("rst_beta_v", beta_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alpha_inst", alpha_inst, 0);
    rst_n = 1'b1;
    issue_ready = 1'b1;

    // RAW split
    drive(2'b11, 32'h00221821, 32'h00612021, 32'h100); cyc(); idle();
    chk("raw_count", count, 2);
    chk("raw_alpha_v", alpha_valid, 1);
    chk("raw_alpha_inst", alpha_inst, 32'h00221821);
    chk("raw_beta_v", beta_valid, 0);
    cyc();
    chk("raw_count2", count, 1);
    chk("raw_alpha_inst2", alpha_inst, 32'h00612021);
    chk("raw_alpha_pc2", alpha_pc, 32'h104);
    cyc();
    chk("raw_empty", alpha_valid, 0);

    // Independent pair
    drive(2'b11, 32'h00221821, 32'h24050001, 32'h200); cyc(); idle();
    chk("ind_beta_v", beta_valid, DUAL);
    chk("ind_beta_inst", beta_inst, 32'h24050001);
    cyc();
    chk("ind_count", count, DUAL ? 0 : 1);
    cyc();
    chk("ind_count_end", count, 0);

    // Memory conflict
    drive(2'b11, 32'h8C060000, 32'hAC060004, 32'h300); cyc(); idle();
    chk("mem_alpha_inst", alpha_inst, 32'h8C060000);
    chk("mem_beta_v", beta_valid, 0);
    cyc();
    chk("mem_count", count, 1);
    chk("mem_alpha_inst2", alpha_inst, 32'hAC060004);
    cyc();

    // Branch held for its delay slot
    issue_ready = 1'b0;
    drive(2'b01, 32'h10000004, 32'h0, 32'h400); cyc(); idle();
    chk("br_count", count, 1);
    chk("br_alpha_hold", alpha_valid, !DUAL);
    drive(2'b01, 32'h24050001, 32'h0, 32'h404); cyc(); idle();
    chk("br_count2", count, 2);
    chk("br_alpha_v", alpha_valid, 1);
    chk("br_alpha_inst", alpha_inst, 32'h10000004);
    chk("br_beta_v", beta_valid, DUAL);
    issue_ready = 1'b1;
    cyc();
    chk("br_pop", count, DUAL ? 0 : 1);
    cyc();
    chk("br_end", count, 0);

    // Privileged alone
    drive(2'b11, 32'h0000000C, 32'h42000018, 32'h500); cyc(); idle();
    chk("priv_alpha_inst", alpha_inst, 32'h0000000C);
    chk("priv_beta_v", beta_valid, 0);
    cyc();
    chk("priv_count", count, 1);
    chk("priv_alpha_inst2", alpha_inst, 32'h42000018);
    chk("priv_beta_v2", beta_valid, 0);
    cyc();

    // Branch whose delay slot is privileged issues alone
    drive(2'b11, 32'h10000004, 32'h0000000C, 32'h600); cyc(); idle();
    chk("brpriv_alpha_v", alpha_valid, 1);
    chk("brpriv_beta_v", beta_valid, 0);
    cyc();
    chk("brpriv_count", count, 1);
    cyc();

    // JAL with delay slot reading $31 issues alone
    drive(2'b11, 32'h0C000000, 32'h03E01021, 32'h700); cyc(); idle();
    chk("jal_alpha_v", alpha_valid, 1);
    chk("jal_beta_v", beta_valid, 0);
    cyc();
    chk("jal_alpha_inst2", alpha_inst, 32'h03E01021);
    cyc();

    // Single push, shifts pointers off alignment for the wrap test
    drive(2'b01, 32'h24070007, 32'h0, 32'h800); cyc(); idle();
    chk("single_count", count, 1);
    chk("single_pc", alpha_pc, 32'h800);
    cyc();
    chk("single_end", count, 0);

    // Fill to full, drop extra push
    issue_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      drive(2'b11, addiu(2*p+1), addiu(2*p+2), pcof(2*p+1)); cyc();
    end
    idle();
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    drive(2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 32'hBAD0); cyc(); idle();
    chk("full_drop", count, 8);
    chk("full_hold_inst", alpha_inst, addiu(1));

    // Release: order preserved across wrap
    issue_ready = 1'b1;
    for (int c = 0; c < (DUAL ? 4 : 8); c++) begin
      int k;
      k = DUAL ? 2*c + 1 : c + 1;
      chk($sformatf("rel_inst%0d", c), alpha_inst, addiu(k));
      chk($sformatf("rel_pc%0d", c), alpha_pc, pcof(k));
      chk($sformatf("rel_beta_v%0d", c), beta_valid, DUAL);
      cyc();
    end
    chk("rel_count", count, 0);

    // Count 7 already blocks pushes
    issue_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive(2'b11, addiu(1), addiu(2), pcof(0)); cyc();
    end
    drive(2'b01, addiu(3), 32'h0, pcof(0)); cyc();
    chk("seven_count", count, 7);
    chk("seven_in_ready", in_ready, 0);
    drive(2'b01, addiu(4), 32'h0, pcof(0)); cyc(); idle();
    chk("seven_drop", count, 7);

    // Flush beats simultaneous push and pop
    flush = 1'b1; issue_ready = 1'b1;
    drive(2'b11, addiu(5), addiu(6), pcof(5)); cyc(); idle();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_alpha_v", alpha_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(2'b01, 32'h24090009, 32'h0, 32'h900); cyc(); idle();
    chk("flush_push_inst", alpha_inst, 32'h24090009);
    chk("flush_push_count", count, 1);
    cyc();

    // Reset in the middle of a push
    issue_ready = 1'b0;
    drive(2'b11, addiu(1), addiu(2), pcof(1)); cyc();
    drive(2'b11, addiu(3), addiu(4), pcof(3));
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_alpha_v", alpha_valid, 0);
    chk("mrst_beta_v", beta_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("mrst_after", count, 0);
    drive(2'b01, 32'h240A000A, 32'h0, 32'hA00); cyc(); idle();
    chk("mrst_push_inst", alpha_inst, 32'h240A000A);
    chk("mrst_push_pc", alpha_pc, 32'hA00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
